// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX register-use info, redirect and LSU stall in;
// pipeline enables, flushes, busy flag and performance counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       i_id_rs1;
   logic [4:0]       i_id_rs2;
   logic             i_id_rs1_used;
   logic             i_id_rs2_used;
   logic [4:0]       i_ex_rd;
   logic             i_ex_rd_wren;
   logic             i_ex_is_load;
   logic             i_ex_redirect;
   logic             i_mem_stall;
   logic             o_pc_en;
   logic             o_if_id_en;
   logic             o_if_id_flush;
   logic             o_id_ex_en;
   logic             o_id_ex_flush;
   logic             o_ex_mem_en;
   logic             o_busy;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;

   modport master (
      output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
      output i_ex_rd, i_ex_rd_wren, i_ex_is_load, i_ex_redirect, i_mem_stall,
      input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
      input  o_ex_mem_en, o_busy, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
      input  i_ex_rd, i_ex_rd_wren, i_ex_is_load, i_ex_redirect, i_mem_stall,
      output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
      output o_ex_mem_en, o_busy, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: load-use bubbles, redirect squashes,
// LSU freeze, plus stall/flush performance counters. Strobes are combinational.
module hazard_ctrl #(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int REDIRECT_CYCLES  = 1,
   parameter int CNT_W            = 32
) (
   input logic          i_clk,
   input logic          i_reset,
   hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_REDIR   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic hazard_s, redir_s, stall_inc_s, flush_inc_s;
   logic pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_flush_s, ex_mem_en_s;

   // A load writing x0 never produces a usable value, so it never stalls.
   assign hazard_s = hz.i_ex_is_load & hz.i_ex_rd_wren & (hz.i_ex_rd != 5'd0) &
                     ((hz.i_id_rs1_used & (hz.i_id_rs1 == hz.i_ex_rd)) |
                      (hz.i_id_rs2_used & (hz.i_id_rs2 == hz.i_ex_rd)));
   assign redir_s  = hz.i_ex_redirect | pend_q;

   // State, bubble/flush down-counter and deferred-redirect flag.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 3'd0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Performance counters; both wrap naturally at 2^CNT_W.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(stall_inc_s);
         flush_cnt_q <= flush_cnt_q + CNT_W'(flush_inc_s);
      end
   end

   // Next state and strobes: mem stall > redirect > LDSTALL/REDIR/load-use > normal.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pend_d        = pend_q;
      stall_inc_s   = 1'b0;
      flush_inc_s   = 1'b0;
      pc_en_s       = 1'b0;
      if_id_en_s    = 1'b0;
      if_id_flush_s = 1'b0;
      id_ex_en_s    = 1'b0;
      id_ex_flush_s = 1'b0;
      ex_mem_en_s   = 1'b0;
      if (!i_reset) begin
         pend_d = 1'b0;
      end else if (hz.i_mem_stall) begin
         pend_d      = pend_q | hz.i_ex_redirect;
         stall_inc_s = 1'b1;
      end else if (redir_s) begin
         {pc_en_s, if_id_en_s, if_id_flush_s}     = 3'b111;
         {id_ex_en_s, id_ex_flush_s, ex_mem_en_s} = 3'b111;
         pend_d      = 1'b0;
         flush_inc_s = 1'b1;
         if (REDIRECT_CYCLES > 1) begin
            state_d = ST_REDIR;
            cnt_d   = 3'(REDIRECT_CYCLES - 1);
         end else begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
         end
      end else begin
         case (state_q)
            ST_REDIR: begin
               {pc_en_s, if_id_en_s, if_id_flush_s}     = 3'b111;
               {id_ex_en_s, id_ex_flush_s, ex_mem_en_s} = 3'b111;
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_REDIR;
               end
            end
            ST_LDSTALL: begin
               {id_ex_en_s, id_ex_flush_s, ex_mem_en_s} = 3'b111;
               stall_inc_s = 1'b1;
               cnt_d       = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_LDSTALL;
               end
            end
            ST_RUN: begin
               if (hazard_s) begin
                  {id_ex_en_s, id_ex_flush_s, ex_mem_en_s} = 3'b111;
                  stall_inc_s = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     state_d = ST_LDSTALL;
                     cnt_d   = 3'(LOAD_USE_BUBBLES - 1);
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s} = 4'b1111;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   assign hz.o_pc_en       = pc_en_s;
   assign hz.o_if_id_en    = if_id_en_s;
   assign hz.o_if_id_flush = if_id_flush_s;
   assign hz.o_id_ex_en    = id_ex_en_s;
   assign hz.o_id_ex_flush = id_ex_flush_s;
   assign hz.o_ex_mem_en   = ex_mem_en_s;
   assign hz.o_busy        = i_reset & (state_q != ST_RUN);
   assign hz.o_stall_cnt   = stall_cnt_q;
   assign hz.o_flush_cnt   = flush_cnt_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Generates the enable and flush strobes for PC, IF_ID, ID_EX and EX_MEM:
  - load-use bubbles, inserted through the ID_EX flush;
  - branch/jump redirect squashes;
  - a global freeze while the LSU is waiting on memory.
- Also keeps stall and flush performance counters.

Parameters:
- LOAD_USE_BUBBLES, 1, number of bubbles inserted per load-use hazard (1..7).
- REDIRECT_CYCLES, 1, number of cycles IF_ID/ID_EX stay flushed after a redirect (1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_id_rs1  in  5  rs1 address of the instruction in ID.
- i_id_rs2  in  5  rs2 address of the instruction in ID.
- i_id_rs1_used  in  1  ID instruction reads rs1.
- i_id_rs2_used  in  1  ID instruction reads rs2.
- i_ex_rd  in  5  rd address in EX.
- i_ex_rd_wren  in  1  EX instruction writes rd.
- i_ex_is_load  in  1  EX instruction is a load (wb_sel = memory).
- i_ex_redirect  in  1  EX resolved a mispredicted branch or jump; PC must load the target.
- i_mem_stall  in  1  LSU busy; the whole pipeline must freeze.
- o_pc_en  out  1  PC register enable.
- o_if_id_en  out  1  IF_ID enable.
- o_if_id_flush  out  1  IF_ID flush.
- o_id_ex_en  out  1  ID_EX enable.
- o_id_ex_flush  out  1  ID_EX flush (takes priority over enable inside ID_EX).
- o_ex_mem_en  out  1  EX_MEM enable.
- o_busy  out  1  FSM is not in RUN.
- o_stall_cnt  out  CNT_W  cycles with o_pc_en=0.
- o_flush_cnt  out  CNT_W  redirect events accepted.

Behaviour:
- FSM states: RUN, LDSTALL, REDIR. 3-bit down-counter `cnt`. Outputs are combinational from state and inputs (zero latency); state and counters are registered.
- Reset (i_reset=0):
  - state=RUN, cnt=0, pend=0, both perf counters 0.
  - All enables and flushes are forced to 0 while reset is asserted.
  - o_busy=0.
- Priority, highest first: i_mem_stall, redirect (i_ex_redirect or pend), load-use, normal.
- i_mem_stall=1:
  - All enables 0, all flushes 0.
  - state and cnt frozen.
  - If i_ex_redirect=1, set pend=1.
  - o_stall_cnt increments.
- Redirect (no mem stall, i_ex_redirect|pend):
  - o_pc_en=1, o_if_id_flush=1, o_id_ex_flush=1, o_if_id_en=1, o_id_ex_en=1, o_ex_mem_en=1.
  - pend cleared; o_flush_cnt increments.
  - If REDIRECT_CYCLES>1: next state REDIR with cnt=REDIRECT_CYCLES-1. Otherwise stay in RUN.
  - A redirect in any state aborts LDSTALL/REDIR and restarts this sequence.
- REDIR state:
  - Same output values as a redirect, except o_flush_cnt does not increment.
  - cnt decrements; go to RUN when cnt reaches 1 on the current cycle.
- Load-use (RUN only): hazard = i_ex_is_load & i_ex_rd_wren & (i_ex_rd!=0) & ((i_id_rs1_used & rs1==rd) | (i_id_rs2_used & rs2==rd)).
  - Outputs: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_ex_mem_en=1, o_stall_cnt increments.
  - If LOAD_USE_BUBBLES>1: go to LDSTALL with cnt=LOAD_USE_BUBBLES-1.
- LDSTALL state:
  - Same outputs as load-use, with no re-evaluation of the hazard.
  - cnt decrements; return to RUN when cnt reaches 1.
- Normal (RUN, no events): all enables 1, all flushes 0.
- rd=x0 never causes a hazard.
- Perf counters wrap at 2^CNT_W.
- o_busy=1 in LDSTALL or REDIR.
- Reset asserted mid-sequence returns to RUN immediately and clears pend.

Test Plan:
- Reset, then idle with no hazards -> all enables 1, flushes 0, counters stay 0 for 10 cycles.
- `lw x5` in EX with `add x6,x5,x1` in ID (rs1=5, used) -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal; stall_cnt=1.
- Load to x0 with rs1=0 in ID -> no stall. Same load with rs1_used=0 -> no stall.
- i_ex_redirect pulse at cycle 5 -> if_id_flush=1 and id_ex_flush=1 at cycle 5 only; flush_cnt=1. With REDIRECT_CYCLES=3 -> flushes held for cycles 5-7, o_busy=1 in cycles 6-7.
- i_mem_stall high for 4 cycles with i_ex_redirect=1 in the first of them -> all enables 0 for 4 cycles, stall_cnt=4. The redirect flush appears in the cycle after i_mem_stall falls; flush_cnt=1.
- LOAD_USE_BUBBLES=3, hazard, then i_reset low during the 2nd bubble -> outputs 0, state RUN. After reset is released: normal outputs, counters 0.
